// File: rtl/logic16_rr_arbiter.sv
// Round-robin arbiter that shares one bitwise logic unit (AND / MUX / NAND) among N_REQ requesters.
// Each grant latches that requester's result and returns it through a valid/ready handshake, tagged with the requester ID.
module logic16_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    input  logic [N_REQ*2-1:0]     op_code,
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] ptr, ptr_next;
    logic [ID_W-1:0] winner, winner_next;
    logic [ID_W-1:0] pick, pick_hi, pick_lo;
    logic            found_hi, found_lo;
    logic [WIDTH-1:0] data_next;
    logic [ID_W-1:0] id_next;
    logic [WIDTH-1:0] sel_a, sel_b, result;
    logic [1:0]      sel_op;
    logic            win_req;

    // Round-robin search: lowest requester at or above ptr, else lowest overall (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_hi && req[i] && (ID_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                pick_hi  = ID_W'(i);
            end
            if (!found_lo && req[i]) begin
                found_lo = 1'b1;
                pick_lo  = ID_W'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Operand mux for the registered winner, plus the grant pulse.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        win_req = 1'b0;
        gnt     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a   = op_a[i*WIDTH +: WIDTH];
                sel_b   = op_b[i*WIDTH +: WIDTH];
                sel_op  = op_code[i*2 +: 2];
                win_req = req[i];
            end
            gnt[i] = (state == ISSUE) && (winner == ID_W'(i)) && req[i];
        end
    end

    // Shared bitwise logic unit.
    always_comb begin
        result = '0;
        case (sel_op)
            2'b00:   result = sel_a & sel_b;
            2'b01:   result = sel_a;
            2'b10:   result = sel_b;
            default: result = ~(sel_a & sel_b);
        endcase
    end

    always_comb begin
        state_next  = state;
        winner_next = winner;
        ptr_next    = ptr;
        data_next   = out_data;
        id_next     = out_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    winner_next = pick;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (win_req) begin
                    data_next  = result;
                    id_next    = winner;
                    ptr_next   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
                    state_next = RESULT;
                end else begin
                    state_next = IDLE;
                end
            end
            RESULT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            winner   <= '0;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            winner   <= winner_next;
            out_data <= data_next;
            out_id   <= id_next;
        end
    end

    assign out_valid = (state == RESULT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_logic16_rr_arbiter.sv
// Bench for logic16_rr_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_logic16_rr_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a, op_b;
    logic [N_REQ*2-1:0]     op_code;
    logic [N_REQ-1:0]       gnt;
    logic                   out_valid, out_ready, busy;
    logic [WIDTH-1:0]       out_data;
    logic [ID_W-1:0]        out_id;

    logic16_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .op_code(op_code), .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: phase 0 waiting, 1 granting, 2 holding result.
    int          m_phase, m_ptr, m_win, m_id;
    logic [15:0] m_data;

    logic [3:0]  obs_gnt;
    logic        obs_valid;
    logic [15:0] obs_data;
    logic [1:0]  obs_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] logic_fn(input logic [1:0] code, input logic [15:0] a, input logic [15:0] b);
        case (code)
            2'd0:    return a & b;
            2'd1:    return a;
            2'd2:    return b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_id = 0; m_data = 16'h0;
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge, return 1 after.
    task automatic cycle();
        logic [3:0] exp_gnt;
        @(negedge clk);
        obs_gnt = gnt; obs_valid = out_valid; obs_data = out_data; obs_id = out_id;
        exp_gnt = (m_phase == 1 && req[m_win]) ? 4'(1 << m_win) : 4'b0;
        check_eq("gnt", 32'(obs_gnt), 32'(exp_gnt));
        check_eq("out_valid", 32'(obs_valid), 32'(m_phase == 2));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("out_data", 32'(obs_data), 32'(m_data));
        check_eq("out_id", 32'(obs_id), 32'(m_id));
        @(posedge clk);
        cyc++;
        case (m_phase)
            0: if (req != 0) begin m_win = rr_pick(req, m_ptr); m_phase = 1; end
            1: if (req[m_win]) begin
                   m_data  = logic_fn(op_code[m_win*2 +: 2], op_a[m_win*16 +: 16], op_b[m_win*16 +: 16]);
                   m_id    = m_win;
                   m_ptr   = (m_win + 1) % 4;
                   m_phase = 2;
               end else m_phase = 0;
            default: if (out_ready) m_phase = 0;
        endcase
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] code);
        op_a[i*16 +: 16] = a; op_b[i*16 +: 16] = b; op_code[i*2 +: 2] = code;
    endtask

    // Single requester op: idle, grant, result. Leaves req low.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] code);
        set_ops(i, a, b, code);
        req = 4'(1 << i);
        cycle();
        cycle();
        check_eq("op_gnt", 32'(obs_gnt), 32'(1 << i));
        req = 4'b0;
        cycle();
    endtask

    int gq[$];
    int gc[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 3};
    logic [15:0] held_data;
    logic [1:0]  held_id;
    logic        seen;

    initial begin
        rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; op_code = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // Single op on requester 2.
        out_ready = 1'b1;
        run_op(2, 16'hF0F0, 16'h0FF0, 2'b00);
        check_eq("single_valid", 32'(obs_valid), 32'd1);
        check_eq("single_data", 32'(obs_data), 32'h00F0);
        check_eq("single_id", 32'(obs_id), 32'd2);
        cycle();

        // Opcodes on requester 1.
        run_op(1, 16'h1234, 16'hABCD, 2'b01);
        check_eq("op01", 32'(obs_data), 32'h1234);
        cycle();
        run_op(1, 16'h1234, 16'hABCD, 2'b10);
        check_eq("op10", 32'(obs_data), 32'hABCD);
        cycle();
        run_op(1, 16'h1234, 16'hABCD, 2'b11);
        check_eq("op11", 32'(obs_data), 32'hFDFB);
        cycle();

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        run_op(0, 16'hBEEF, 16'h0000, 2'b01);
        check_eq("pre_rst_data", 32'(obs_data), 32'hBEEF);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round robin with all requesting, then 1001 after the fifth grant.
        for (int i = 0; i < 4; i++) set_ops(i, 16'(16'h1111 * (i + 1)), 16'hFF00, 2'(i));
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 40 && gq.size() < 6; c++) begin
            cycle();
            if (obs_gnt != 0) begin
                gq.push_back($clog2(obs_gnt));
                gc.push_back(cyc);
                if (gq.size() == 5) req = 4'b1001;
            end
        end
        check_eq("rr_count", 32'(gq.size()), 32'd6);
        if (gq.size() == 6) begin
            for (int i = 0; i < 6; i++) check_eq("rr_order", 32'(gq[i]), 32'(exp_order[i]));
            for (int i = 0; i < 4; i++) check_eq("rr_spacing", 32'(gc[i+1] - gc[i]), 32'd3);
        end

        // Backpressure: result held for 5 cycles, no grants meanwhile.
        req = 4'b1111; out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cycle();
            seen = obs_valid;
        end
        check_eq("bp_reach", 32'(seen), 32'd1);
        held_data = obs_data; held_id = obs_id;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_eq("bp_valid", 32'(obs_valid), 32'd1);
            check_eq("bp_data", 32'(obs_data), 32'(held_data));
            check_eq("bp_id", 32'(obs_id), 32'(held_id));
            check_eq("bp_nognt", 32'(obs_gnt), 32'd0);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            cycle();
            seen = (obs_gnt != 0);
        end
        check_eq("bp_next_gnt", 32'(seen), 32'd1);
        req = 4'b0;
        repeat (3) cycle();

        // Withdrawal: ptr to 0 via requester 3, pulse req[1], then 0011 grants 0.
        run_op(3, 16'h5A5A, 16'hA5A5, 2'b00);
        cycle();
        req = 4'b0010;
        cycle();
        req = 4'b0000;
        cycle();
        check_eq("wd_nognt", 32'(obs_gnt), 32'd0);
        cycle();
        check_eq("wd_novalid", 32'(obs_valid), 32'd0);
        req = 4'b0011;
        cycle();
        cycle();
        check_eq("wd_gnt0", 32'(obs_gnt), 32'b0001);
        req = 4'b0;
        repeat (3) cycle();

        // Random traffic obeying the requester contract.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        set_ops(i, 16'($urandom), 16'($urandom), 2'($urandom));
                        req[i] = 1'b1;
                    end
                end else if (obs_gnt[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                    else set_ops(i, 16'($urandom), 16'($urandom), 2'($urandom));
                end else if ($urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/logic16_rr_arbiter.md
Name: logic16_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 16-bit bitwise logic unit (AND16 / MUX16 / NAND16) among N_REQ requesters. It samples requests, grants one requester, latches that requester's operands, and computes the result through the shared datapath. It then presents the result with a valid/ready handshake, tagged with the requester ID. It sits between the client blocks and the single combinational logic unit of the 01/ gate library.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width
ID_W, 2, width of requester ID (must be >= clog2(N_REQ))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
req  in  N_REQ  per-requester request; held high until gnt seen
op_a  in  N_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH]
op_b  in  N_REQ*WIDTH  packed operand B, same packing
op_code  in  N_REQ*2  packed opcode: 00 a&b, 01 a (mux sel=0), 10 b (mux sel=1), 11 ~(a&b)
gnt  out  N_REQ  one-hot grant, one-cycle pulse
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  registered result
out_id  out  ID_W  index of requester that owns out_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; gnt=0; out_valid=0; out_data=0; out_id=0; busy=0; rr pointer=0. Reset mid-op discards any latched operands or pending result with no grant or valid emitted.
- FSM states: IDLE, ISSUE, RESULT.
- IDLE, |req=1 at the clock edge:
  - Winner = first i with req[i]=1, searching from ptr upward and wrapping modulo N_REQ.
  - winner is registered and state goes to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE, req[winner]=1:
  - gnt[winner]=1 for exactly this cycle.
  - At the edge, out_data <= f(op_code[winner], op_a[winner], op_b[winner]), out_id <= winner, and ptr <= (winner+1) mod N_REQ.
  - State goes to RESULT.
- ISSUE, req[winner]=0 (request withdrawn): no gnt, ptr unchanged, return to IDLE (abort).
- RESULT: out_valid=1. out_data and out_id are held stable while out_ready=0. On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: req seen in IDLE at edge k; gnt high in cycle k+1; out_valid high from cycle k+2. Minimum 3 cycles per op with out_ready tied high.
- No new grant is issued while in ISSUE or RESULT. Requests arriving then wait and are arbitrated on return to IDLE.
- Requester contract: hold op_a, op_b and op_code stable from req rise through its gnt cycle. After gnt, the requester must drop req unless it wants another op; a held req is re-arbitrated fairly in round-robin order.
- Fairness: with all N_REQ requesting continuously, grants cycle 0,1,2,3,0,... with no requester starved.
- The result function is purely bitwise; there is no carry and no width extension.
- gnt is never multi-hot.
- busy = (state != IDLE).

Test Plan:
- Reset: drive rst_n=0 mid-RESULT holding out_data=16'hBEEF -> out_valid=0, out_data=0, gnt=0 immediately (async, no clock edge needed); after release, first grant goes to req[0] when req=4'b1111.
- Single op: req[2]=1, op_a[2]=16'hF0F0, op_b[2]=16'h0FF0, op_code[2]=00, out_ready=1 -> gnt=4'b0100 in cycle 1; in cycle 2 out_valid=1, out_data=16'h00F0, out_id=2.
- Opcodes on requester 1 with a=16'h1234, b=16'hABCD -> op 01 gives 16'h1234, op 10 gives 16'hABCD, op 11 gives 16'hFFFF & ~(16'h0204) = 16'hFDFB.
- Round robin: req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles; then req=4'b1001 after a grant to 0 -> next grant goes to 3.
- Backpressure: out_ready=0 for 5 cycles in RESULT -> out_valid stays 1 and out_data/out_id stay stable; no gnt while req=4'b1111; out_ready=1 -> IDLE, then next grant.
- Withdrawal: req[1] pulsed for 1 cycle only -> ISSUE aborts with gnt=0 and no out_valid; ptr unchanged, so a following req=4'b0011 grants 0.
